wb_txn_tracker: RTL and testbench

- Parametrised Wishbone (pipelined) transaction tracker and protocol watchdog.
- Taps a master/slave bus pair non-intrusively. Counts requests, responses and writes per bus cycle, and reports outstanding depth and bus phase.
- Raises sticky protocol-violation flags: stall and ack timeouts, orphan responses, depth overflow, RMW-hold misuse.
- Synthesisable; used in simulation benches and as an on-chip debug probe behind a bus-status register.

---
 rtl/wb_txn_tracker.sv | 141 ++++++++++++++
 tb/tb_wb_txn_tracker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_txn_tracker.sv
// Non-intrusive Wishbone (pipelined) transaction tracker and protocol watchdog.
// Optional per-request latency measurement is enabled with `define WBTRK_LATENCY_EN.
module wb_txn_tracker #(
  parameter int LGDEPTH            = 4,
  parameter int MAX_STALL          = 0,
  parameter int MAX_ACK_DELAY      = 0,
  parameter int DLYW               = 16,
  parameter int OPT_MINCLOCK_DELAY = 0,
  parameter int OPT_RMW            = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic               i_wb_stall,
  input  logic               i_wb_ack,
  input  logic               i_wb_err,
  output logic [LGDEPTH-1:0] o_nreqs,
  output logic [LGDEPTH-1:0] o_nacks,
  output logic [LGDEPTH-1:0] o_nwrites,
  output logic [LGDEPTH-1:0] o_outstanding,
  output logic [1:0]         o_phase,
  output logic               o_abort,
  output logic [7:0]         o_errflags
`ifdef WBTRK_LATENCY_EN
  ,
  output logic [DLYW-1:0]    o_max_latency
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HOLD = 2'd2} phase_t;

  localparam logic [DLYW-1:0] STALL_LIM = DLYW'(MAX_STALL);
  localparam logic [DLYW-1:0] ACK_LIM   = DLYW'(MAX_ACK_DELAY);

  phase_t             phase;
  logic               req, rsp, stalling, ackwait;
  logic               cyc_q, hold_q;
  logic [LGDEPTH-1:0] nreqs_nxt, nacks_nxt, out_nxt;
  logic [LGDEPTH:0]   orph_sum;
  logic [DLYW-1:0]    stall_cnt, stall_nxt, ackw_cnt, ackw_nxt;
  logic [7:0]         viol;

  assign req      = i_wb_cyc & i_wb_stb & !i_wb_stall;
  assign rsp      = i_wb_cyc & (i_wb_ack | i_wb_err);
  assign stalling = i_wb_cyc & i_wb_stb & i_wb_stall;

  assign o_outstanding = i_wb_cyc ? (o_nreqs - o_nacks) : '0;
  assign o_phase       = phase;

  assign nreqs_nxt = o_nreqs + LGDEPTH'(req);
  assign nacks_nxt = o_nacks + LGDEPTH'(rsp);
  assign out_nxt   = nreqs_nxt - nacks_nxt;

  assign ackwait   = (o_outstanding != '0) & !rsp;
  assign stall_nxt = (&stall_cnt) ? stall_cnt : stall_cnt + 1'b1;
  assign ackw_nxt  = (&ackw_cnt)  ? ackw_cnt  : ackw_cnt + 1'b1;

  // A same-cycle request may legally satisfy a response unless min-clock delay is required.
  assign orph_sum = {1'b0, o_outstanding}
                  + (LGDEPTH+1)'(req & (OPT_MINCLOCK_DELAY == 0));

  always_comb begin
    viol    = '0;
    viol[0] = rsp & (orph_sum == '0);
    viol[1] = (MAX_STALL != 0) & stalling & (stall_nxt >= STALL_LIM);
    viol[2] = (MAX_ACK_DELAY != 0) & ackwait & (ackw_nxt >= ACK_LIM);
    viol[3] = req & (&o_outstanding);
    viol[4] = i_wb_stb & !i_wb_cyc;
    viol[5] = i_wb_ack & i_wb_err;
    viol[6] = (OPT_RMW == 0) & (phase == HOLD) & hold_q & i_wb_cyc;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_nreqs    <= '0;
      o_nacks    <= '0;
      o_nwrites  <= '0;
      phase      <= IDLE;
      o_abort    <= 1'b0;
      o_errflags <= '0;
      cyc_q      <= 1'b0;
      hold_q     <= 1'b0;
      stall_cnt  <= '0;
      ackw_cnt   <= '0;
    end else begin
      if (!i_wb_cyc) begin
        o_nreqs   <= '0;
        o_nacks   <= '0;
        o_nwrites <= '0;
      end else begin
        o_nreqs   <= nreqs_nxt;
        o_nacks   <= nacks_nxt;
        o_nwrites <= o_nwrites + LGDEPTH'(req & i_wb_we);
      end

      if (!i_wb_cyc)
        phase <= IDLE;
      else
        case (phase)
          IDLE:    if (req) phase <= ACTIVE;
          ACTIVE:  if (out_nxt == '0) phase <= HOLD;
          HOLD:    if (req) phase <= ACTIVE;
          default: phase <= IDLE;
        endcase

      // Counters still hold the last in-cycle totals on the cycle cyc falls.
      o_abort    <= cyc_q & !i_wb_cyc & (o_nreqs != o_nacks);
      cyc_q      <= i_wb_cyc;
      hold_q     <= (phase == HOLD) & i_wb_cyc;
      stall_cnt  <= stalling ? stall_nxt : '0;
      ackw_cnt   <= ackwait  ? ackw_nxt  : '0;
      o_errflags <= o_errflags | viol;
    end
  end

`ifdef WBTRK_LATENCY_EN
  // Stamp FIFO is addressed by the request/response counters, so it flushes with them.
  logic [DLYW-1:0] now, lat;
  logic [DLYW-1:0] stamps [0:(1<<LGDEPTH)-1];
  logic            pop;

  assign pop = rsp & ((o_outstanding != '0) | req);
  assign lat = (o_outstanding != '0) ? now - stamps[o_nacks] : '0;

  always_ff @(posedge i_clk)
    if (req) stamps[o_nreqs] <= now;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      now           <= '0;
      o_max_latency <= '0;
    end else begin
      now <= now + 1'b1;
      if (pop && lat > o_max_latency) o_max_latency <= lat;
    end
  end
`endif

endmodule

// File: tb/tb_wb_txn_tracker.sv
// Directed bench: three tracker instances with different parameters share one stimulus bus.
module tb_wb_txn_tracker;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0, stall = 1'b0, ack = 1'b0, err = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  always #5 i_clk = ~i_clk;

  // dut0: LGDEPTH=4, stall/ack timeouts enabled
  logic [3:0] nreq0, nack0, nwr0, out0;
  logic [1:0] ph0;
  logic       ab0;
  logic [7:0] ef0;
  // dut1: min-clock delay required
  logic [3:0] nreq1, nack1, nwr1, out1;
  logic [1:0] ph1;
  logic       ab1;
  logic [7:0] ef1;
  // dut2: LGDEPTH=2
  logic [1:0] nreq2, nack2, nwr2, out2;
  logic [1:0] ph2;
  logic       ab2;
  logic [7:0] ef2;
`ifdef WBTRK_LATENCY_EN
  logic [15:0] lat0, lat1, lat2;
`endif

  wb_txn_tracker #(.LGDEPTH(4), .MAX_STALL(4), .MAX_ACK_DELAY(3)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err),
    .o_nreqs(nreq0), .o_nacks(nack0), .o_nwrites(nwr0), .o_outstanding(out0),
    .o_phase(ph0), .o_abort(ab0), .o_errflags(ef0)
`ifdef WBTRK_LATENCY_EN
    , .o_max_latency(lat0)
`endif
  );

  wb_txn_tracker #(.LGDEPTH(4), .OPT_MINCLOCK_DELAY(1)) dut1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err),
    .o_nreqs(nreq1), .o_nacks(nack1), .o_nwrites(nwr1), .o_outstanding(out1),
    .o_phase(ph1), .o_abort(ab1), .o_errflags(ef1)
`ifdef WBTRK_LATENCY_EN
    , .o_max_latency(lat1)
`endif
  );

  wb_txn_tracker #(.LGDEPTH(2)) dut2 (
    .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err),
    .o_nreqs(nreq2), .o_nacks(nack2), .o_nwrites(nwr2), .o_outstanding(out2),
    .o_phase(ph2), .o_abort(ab2), .o_errflags(ef2)
`ifdef WBTRK_LATENCY_EN
    , .o_max_latency(lat2)
`endif
  );

  // Apply one bus cycle, then land 1 time unit after the edge for checking.
  task automatic step(input logic c, input logic s, input logic w,
                      input logic st, input logic a, input logic e);
    cyc = c; stb = s; we = w; stall = st; ack = a; err = e;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    i_reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_nreqs", 32'(nreq0), 0);
    chk("rst_nacks", 32'(nack0), 0);
    chk("rst_out",   32'(out0), 0);
    chk("rst_phase", 32'(ph0), 0);
    chk("rst_abort", 32'(ab0), 0);
    chk("rst_flags", 32'(ef0), 0);

    // three reads, each acked two cycles after its request
    step(1, 1, 0, 0, 0, 0);
    chk("rd_nreq1", 32'(nreq0), 1);
    chk("rd_ph_act", 32'(ph0), 1);
    step(1, 1, 0, 0, 0, 0);
    chk("rd_nreq2", 32'(nreq0), 2);
    step(1, 1, 0, 0, 1, 0);
    chk("rd_nreq3", 32'(nreq0), 3);
    chk("rd_nack1", 32'(nack0), 1);
    chk("rd_out2", 32'(out0), 2);
    step(1, 0, 0, 0, 1, 0);
    chk("rd_out1", 32'(out0), 1);
    step(1, 0, 0, 0, 1, 0);
    chk("rd_nack3", 32'(nack0), 3);
    chk("rd_ph_hold", 32'(ph0), 2);
    step(0, 0, 0, 0, 0, 0);
    chk("rd_ph_idle", 32'(ph0), 0);
    chk("rd_cnt_clr", 32'(nreq0), 0);
    chk("rd_no_abort", 32'(ab0), 0);
    chk("rd_flags", 32'(ef0), 0);

    // stall timeout at MAX_STALL=4
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0);
    chk("stall3_flag", 32'(ef0[1]), 0);
    step(1, 1, 0, 1, 0, 0);
    chk("stall4_flag", 32'(ef0[1]), 1);
    step(1, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("stall_sticky", 32'(ef0), 32'h02);

    // orphan ack with nothing issued
    do_reset();
    step(1, 0, 0, 0, 1, 0);
    chk("orphan_flag", 32'(ef0), 32'h01);
    chk("orphan_nack", 32'(nack0), 1);

    // ack in the same cycle as the first request
    do_reset();
    step(1, 1, 0, 0, 1, 0);
    chk("samecyc_mcd0", 32'(ef0), 0);
    chk("samecyc_mcd1", 32'(ef1), 32'h01);
    chk("samecyc_out", 32'(out0), 0);
    step(0, 0, 0, 0, 0, 0);

    // depth overflow with LGDEPTH=2
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    chk("ovf_out3", 32'(out2), 3);
    chk("ovf_pre", 32'(ef2[3]), 0);
    step(1, 1, 0, 0, 0, 0);
    chk("ovf_flag", 32'(ef2), 32'h08);
    chk("ovf_wrap", 32'(out2), 0);

    // two writes abandoned by dropping cyc
    do_reset();
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("abt_nwr", 32'(nwr0), 2);
    chk("abt_pre", 32'(ab0), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("abt_pulse", 32'(ab0), 1);
    chk("abt_nreq0", 32'(nreq0), 0);
    chk("abt_nwr0", 32'(nwr0), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("abt_once", 32'(ab0), 0);
    chk("abt_flags", 32'(ef0), 0);

    // ack timeout at MAX_ACK_DELAY=3
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    idle(2);
    chk("ackto_pre", 32'(ef0[2]), 0);
    idle(1);
    chk("ackto_flag", 32'(ef0), 32'h04);

    // stb without cyc, then ack together with err
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    chk("stb_nocyc", 32'(ef0), 32'h10);
    do_reset();
    step(0, 0, 0, 0, 1, 1);
    chk("ack_err", 32'(ef0), 32'h20);

    // reset mid-cycle: a late ack for the pre-reset request is an orphan
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    i_reset = 1'b1;
    step(1, 1, 0, 0, 0, 0);
    i_reset = 1'b0;
    chk("midrst_nreq", 32'(nreq0), 0);
    step(1, 0, 0, 0, 1, 0);
    chk("midrst_orph", 32'(ef0), 32'h01);
    step(0, 0, 0, 0, 0, 0);

`ifdef WBTRK_LATENCY_EN
    // latencies 1, 5, 3 -> max 5
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("lat_first", 32'(lat0), 1);
    step(1, 1, 0, 0, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 1, 0);
    chk("lat_max", 32'(lat0), 5);
    step(0, 0, 0, 0, 0, 0);
    chk("lat_keep", 32'(lat0), 5);
    do_reset();
    chk("lat_rst", 32'(lat0), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
